// File: rtl/pipeline_controller_pkg.sv
// Shared CPU pipeline-control definitions: controller state encoding and
// default MEM-stage watchdog limit.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } pc_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int unsigned STALL_CNT_W            = 32;

  // Width needed to hold a dwell count up to and including the limit.
  function automatic int unsigned dwell_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detector.sv
// Combinational load-use detector: the ID-stage instruction reads the
// register a load in EX is about to write. x0 never creates a hazard.
module hazard_detector (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  output logic       load_use
);

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((ex_rd == rs1) || (ex_rd == rs2));

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline write-enable / flush sequencer: memory stalls, branch redirects,
// load-use bubbles, stall statistics and a MEM-wait watchdog.
//
// state       | meaning
// RUN         | normal flow; handles single-cycle redirect and load-use bubble
// MEM_WAIT    | RAM access outstanding, whole pipe frozen
// REDIRECT    | one-cycle flush of a redirect deferred by a memory stall
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4:0]             id_rs1_address,
  input  logic [4:0]             id_rs2_address,
  input  logic [4:0]             ex_rd_address,
  input  logic                   ex_is_load,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   mem_redirect,
  output logic                   pc_wren,
  output logic                   if_id_wren,
  output logic                   id_ex_wren,
  output logic                   ex_mem_wren,
  output logic                   mem_wb_wren,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   mem_timeout,
  output logic [1:0]             state
);

  localparam int unsigned DWELL_W = dwell_width(TIMEOUT_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(TIMEOUT_CYCLES);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  pc_state_e              state_q, state_d;
  logic                   pending_q, pending_d;
  logic [DWELL_W-1:0]     dwell_q, dwell_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   timeout_q, timeout_d;

  logic load_use;
  logic mem_stall;
  logic [DWELL_W-1:0] dwell_inc;
  logic pc_w, if_id_w, id_ex_w, ex_mem_w, mem_wb_w;
  logic if_id_f, id_ex_f, ex_mem_f;

  hazard_detector u_hazard_detector (
    .rs1        (id_rs1_address),
    .rs2        (id_rs2_address),
    .ex_rd      (ex_rd_address),
    .ex_is_load (ex_is_load),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;
  assign dwell_inc = dwell_q + DWELL_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      pending_q   <= 1'b0;
      dwell_q     <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      dwell_q     <= dwell_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dwell_d   = '0;
    timeout_d = timeout_q;
    pc_w      = 1'b1;
    if_id_w   = 1'b1;
    id_ex_w   = 1'b1;
    ex_mem_w  = 1'b1;
    mem_wb_w  = 1'b1;
    if_id_f   = 1'b0;
    id_ex_f   = 1'b0;
    ex_mem_f  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          {pc_w, if_id_w, id_ex_w, ex_mem_w, mem_wb_w} = '0;
          state_d   = ST_MEM_WAIT;
          pending_d = mem_redirect;
        end else if (mem_redirect) begin
          {if_id_f, id_ex_f, ex_mem_f} = 3'b111;
        end else if (load_use) begin
          pc_w    = 1'b0;
          if_id_w = 1'b0;
          id_ex_f = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          pending_d = pending_q || mem_redirect;
          state_d   = (pending_q || mem_redirect) ? ST_REDIRECT : ST_RUN;
        end else begin
          {pc_w, if_id_w, id_ex_w, ex_mem_w, mem_wb_w} = '0;
          pending_d = pending_q || mem_redirect;
          // Watchdog abandons the access and any redirect riding on it.
          if (dwell_inc == DWELL_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = ST_RUN;
            pending_d = 1'b0;
          end else begin
            dwell_d = dwell_inc;
          end
        end
      end
      ST_REDIRECT: begin
        {if_id_f, id_ex_f, ex_mem_f} = 3'b111;
        pending_d = 1'b0;
        state_d   = ST_RUN;
      end
      default: begin
        {pc_w, if_id_w, id_ex_w, ex_mem_w, mem_wb_w} = '0;
        pending_d = 1'b0;
        state_d   = ST_RUN;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (!pc_w && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Controls are forced quiet while reset is held, independent of the clock.
  assign pc_wren      = reset_n && pc_w;
  assign if_id_wren   = reset_n && if_id_w;
  assign id_ex_wren   = reset_n && id_ex_w;
  assign ex_mem_wren  = reset_n && ex_mem_w;
  assign mem_wb_wren  = reset_n && mem_wb_w;
  assign if_id_flush  = reset_n && if_id_f;
  assign id_ex_flush  = reset_n && id_ex_f;
  assign ex_mem_flush = reset_n && ex_mem_f;

  assign stall_cycles = stall_cnt_q;
  assign mem_timeout  = timeout_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  id_rs1_address = '0, id_rs2_address = '0, ex_rd_address = '0;
  logic        ex_is_load = 1'b0, mem_req = 1'b0, mem_ready = 1'b0, mem_redirect = 1'b0;
  logic        pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [31:0] stall_cycles;
  logic        mem_timeout;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_pass = 0;

  // model: what the pipe is doing, in plain terms
  bit     m_waiting;
  bit     m_flush_next;
  bit     m_pending;
  int     m_waited;
  longint m_stalls;
  bit     m_to;

  pipeline_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .ex_rd_address(ex_rd_address), .ex_is_load(ex_is_load),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_redirect(mem_redirect),
    .pc_wren(pc_wren), .if_id_wren(if_id_wren), .id_ex_wren(id_ex_wren),
    .ex_mem_wren(ex_mem_wren), .mem_wb_wren(mem_wb_wren),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .stall_cycles(stall_cycles), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_waiting = 0; m_flush_next = 0; m_pending = 0;
    m_waited = 0; m_stalls = 0; m_to = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wren"}, {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren}, 0);
    chk({tag, "_flush"}, {if_id_flush, id_ex_flush, ex_mem_flush}, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_stalls"}, stall_cycles, 0);
    chk({tag, "_timeout"}, mem_timeout, 0);
  endtask

  // Called just after a rising edge: reset lands between edges.
  task automatic do_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    mem_req = 0; mem_ready = 0; mem_redirect = 0; ex_is_load = 0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic step(input bit req, input bit rdy, input bit redir, input bit ld,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bit lu, stall;
    bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fl3, e_idex_fl;
    int e_state;
    @(negedge clk);
    mem_req = req; mem_ready = rdy; mem_redirect = redir;
    ex_is_load = ld; ex_rd_address = rd; id_rs1_address = rs1; id_rs2_address = rs2;
    #1;
    lu = ld && (rd != 0) && (rd == rs1 || rd == rs2);
    e_state = m_flush_next ? 2 : (m_waiting ? 1 : 0);
    {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
    e_fl3 = 0; e_idex_fl = 0;
    stall = 0;
    if (m_flush_next) e_fl3 = 1;
    else if (m_waiting) stall = !rdy;
    else if (req && !rdy) stall = 1;
    else if (redir) e_fl3 = 1;
    else if (lu) begin e_pc = 0; e_ifid = 0; e_idex_fl = 1; end
    if (stall) {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;

    chk("pc_wren", pc_wren, e_pc);
    chk("if_id_wren", if_id_wren, e_ifid);
    chk("id_ex_wren", id_ex_wren, e_idex);
    chk("ex_mem_wren", ex_mem_wren, e_exmem);
    chk("mem_wb_wren", mem_wb_wren, e_memwb);
    chk("if_id_flush", if_id_flush, e_fl3);
    chk("id_ex_flush", id_ex_flush, e_fl3 | e_idex_fl);
    chk("ex_mem_flush", ex_mem_flush, e_fl3);
    chk("state", state, e_state);
    chk("stall_cycles", stall_cycles, m_stalls[31:0]);
    chk("mem_timeout", mem_timeout, m_to);

    @(posedge clk);
    if (!e_pc && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (m_flush_next) begin
      m_flush_next = 0; m_pending = 0;
    end else if (m_waiting) begin
      if (rdy) begin
        m_waiting = 0; m_flush_next = m_pending || redir; m_pending = 0; m_waited = 0;
      end else begin
        m_pending = m_pending || redir;
        m_waited++;
        if (m_waited == TO) begin
          m_to = 1; m_waiting = 0; m_waited = 0; m_pending = 0;
        end
      end
    end else if (req && !rdy) begin
      m_waiting = 1; m_pending = redir; m_waited = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    #1;
    check_reset_outputs("in_reset");
    @(negedge clk);
    reset_n = 1'b1;

    idle();
    // load-use on rs1, then clean
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd9);
    idle();
    chk("lu_stalls", stall_cycles, 1);
    // load to x0 never stalls
    step(0, 0, 0, 1, 5'd0, 5'd3, 5'd0);
    // three-cycle memory wait
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    idle();
    chk("memwait_stalls", stall_cycles, 4);
    // single-cycle access
    step(1, 1, 0, 0, 0, 0, 0);
    // redirect alone, and redirect beating load-use
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 5'd7, 5'd1, 5'd7);
    // redirect while waiting, ready two cycles later
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0);
    idle();
    // watchdog
    for (int i = 0; i < TO + 1; i++) step(1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("timeout_set", mem_timeout, 1);
    idle();
    do_reset("rst_after_to");
    // reset in the middle of a wait with a redirect pending
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    do_reset("rst_mid_wait");
    idle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(249) == 0) do_reset("rst_rand");
      else step($urandom_range(2) == 0, $urandom_range(1) == 0, $urandom_range(5) == 0,
                $urandom_range(1) == 0, 5'($urandom_range(3)),
                5'($urandom_range(3)), 5'($urandom_range(3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Ports SHALL be: clk input 1 (rising-edge clock); reset_n input 1 (asynchronous, active-low reset).
REQ-002 Inputs SHALL be: id_rs1_address 5 and id_rs2_address 5 (source registers in ID); ex_rd_address 5 (destination register in EX); ex_is_load 1 (EX holds a load); mem_req 1 (MEM stage needs RAM); mem_ready 1 (RAM done this cycle); mem_redirect 1 (branch/jump taken, resolved in MEM).
REQ-003 Outputs SHALL be pc_wren, if_id_wren, id_ex_wren, ex_mem_wren and mem_wb_wren, each 1 bit: write enables for the PC and each pipeline register.
REQ-004 Outputs SHALL also be if_id_flush, id_ex_flush and ex_mem_flush, each 1 bit: load a bubble (all-zero control) instead of the input.
REQ-005 Outputs SHALL also be: stall_cycles 32 (saturating count of stalled cycles); mem_timeout 1 (sticky watchdog error); state 2 (current FSM state, debug).
REQ-006 Parameter TIMEOUT_CYCLES SHALL have default 255 and SHALL set the maximum MEM_WAIT dwell before mem_timeout.

Function
REQ-007 The FSM SHALL have states RUN=0, MEM_WAIT=1 and REDIRECT=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-008 In RUN with no hazard, all five wren outputs SHALL be 1 and all flush outputs SHALL be 0.
REQ-009 Memory stall: in RUN, mem_req=1 with mem_ready=0 SHALL drive all wren outputs to 0 combinationally and SHALL move the FSM to MEM_WAIT.
REQ-010 In MEM_WAIT, all wren outputs SHALL stay 0 until mem_ready=1; on that cycle all wren outputs SHALL be 1 and the next state SHALL be RUN, or REDIRECT if a redirect is pending.
REQ-011 mem_req=1 with mem_ready=1 in RUN SHALL cause no stall, i.e. single-cycle access.
REQ-012 Redirect in RUN without a memory stall: if_id_flush, id_ex_flush and ex_mem_flush SHALL be 1 for exactly that cycle, with all wren outputs 1; the FSM SHALL stay in RUN.
REQ-013 A redirect that arrives during a memory stall (RUN-to-MEM_WAIT entry or MEM_WAIT) SHALL set redirect_pending.
REQ-014 REDIRECT state SHALL last exactly 1 cycle: it asserts the three flush outputs with all wren outputs 1, clears redirect_pending, then returns to RUN.
REQ-015 Load-use hazard is ex_is_load=1, ex_rd_address!=0 and ex_rd_address equal to id_rs1_address or id_rs2_address.
REQ-016 On a load-use hazard in RUN: pc_wren=0, if_id_wren=0, id_ex_wren=1, id_ex_flush=1; ex_mem_wren and mem_wb_wren SHALL be 1.
REQ-017 Priority SHALL be: memory stall > redirect > load-use; a redirect coinciding with load-use SHALL flush and SHALL NOT stall.
REQ-018 stall_cycles SHALL increment by 1 on every cycle in which pc_wren=0, and SHALL saturate at 0xFFFFFFFF without wrapping.
REQ-019 A dwell counter SHALL count consecutive MEM_WAIT cycles; reaching TIMEOUT_CYCLES SHALL set mem_timeout=1 and SHALL force the FSM to RUN.
REQ-020 mem_timeout SHALL remain set until reset; the dwell counter SHALL clear on leaving MEM_WAIT.

Reset
REQ-021 reset_n=0 SHALL immediately force: state=RUN, redirect_pending=0, dwell counter=0, stall_cycles=0, mem_timeout=0.
REQ-022 While reset_n=0, all wren outputs SHALL be 0 and all flush outputs SHALL be 0.
REQ-023 Reset asserted mid-MEM_WAIT SHALL discard the stall and any pending redirect; the first cycle after release SHALL be RUN with no hazard latched.

Structure
REQ-024 The state enum and its encodings SHALL live in the shared CPU package, together with the default TIMEOUT_CYCLES constant.
REQ-025 Load-use comparison SHALL be a combinational sub-module, hazard_detector (inputs: rs1, rs2, ex_rd, ex_is_load; output: load_use).
REQ-026 FSM, counters and output decode SHALL stay in pipeline_controller.

Verification
REQ-027 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5 for 1 cycle -> pc_wren=0, if_id_wren=0, id_ex_flush=1 for 1 cycle; stall_cycles=1.
REQ-028 Load from x0: ex_is_load=1, ex_rd=0, id_rs2=0 -> no stall, all wren=1.
REQ-029 Memory wait: mem_req=1, mem_ready low 3 cycles then high -> wren=0 for 3 cycles then 1; state RUN->MEM_WAIT->RUN; stall_cycles=3.
REQ-030 Redirect during stall: mem_redirect pulse while in MEM_WAIT, mem_ready 2 cycles later -> REDIRECT for 1 cycle with three flushes=1, then RUN.
REQ-031 Timeout with TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_timeout=1 after 4 MEM_WAIT cycles, state=RUN, flag held until reset_n=0.
REQ-032 Async reset mid-MEM_WAIT between clock edges -> outputs at reset values immediately; stall_cycles=0.
